// File: rtl/ec_fpk_elem_serialiser_if.sv
// Bundle of all handshake/bus signals of ec_fpk_elem_serialiser.
// Latency: none (wires only).
// Backpressure: carries o_rdy, i_unit_rdy, o_unit_rdy and i_rdy between the parties.
// Ports:
//   upstream   : i_dat, i_val, i_ctl, i_err -> o_rdy
//   unit req   : o_unit_dat/val/ctl/sop/eop/err <- i_unit_rdy
//   unit result: i_unit_dat/val/ctl/err -> o_unit_rdy
//   downstream : o_dat, o_val, o_ctl, o_err <- i_rdy
// Modport slave is the serialiser's view; master is the environment's view.
interface ec_fpk_elem_serialiser_if #(
   parameter int FE_BITS  = 381,
   parameter int NUM_ELEM = 2,
   parameter int CTL_BITS = 16
);
   // upstream operand stream
   logic [2*NUM_ELEM*FE_BITS-1:0] i_dat;
   logic                          i_val;
   logic [CTL_BITS-1:0]           i_ctl;
   logic                          i_err;
   logic                          o_rdy;
   // element request towards the shared unit
   logic [2*FE_BITS-1:0]          o_unit_dat;
   logic                          o_unit_val;
   logic [CTL_BITS-1:0]           o_unit_ctl;
   logic                          o_unit_sop;
   logic                          o_unit_eop;
   logic                          o_unit_err;
   logic                          i_unit_rdy;
   // element result from the shared unit
   logic [FE_BITS-1:0]            i_unit_dat;
   logic                          i_unit_val;
   logic [CTL_BITS-1:0]           i_unit_ctl;
   logic                          i_unit_err;
   logic                          o_unit_rdy;
   // reassembled result stream
   logic [NUM_ELEM*FE_BITS-1:0]   o_dat;
   logic                          o_val;
   logic [CTL_BITS-1:0]           o_ctl;
   logic                          o_err;
   logic                          i_rdy;

   modport slave (
      input  i_dat, i_val, i_ctl, i_err,
      output o_rdy,
      output o_unit_dat, o_unit_val, o_unit_ctl, o_unit_sop, o_unit_eop, o_unit_err,
      input  i_unit_rdy,
      input  i_unit_dat, i_unit_val, i_unit_ctl, i_unit_err,
      output o_unit_rdy,
      output o_dat, o_val, o_ctl, o_err,
      input  i_rdy
   );

   modport master (
      output i_dat, i_val, i_ctl, i_err,
      input  o_rdy,
      input  o_unit_dat, o_unit_val, o_unit_ctl, o_unit_sop, o_unit_eop, o_unit_err,
      output i_unit_rdy,
      output i_unit_dat, i_unit_val, i_unit_ctl, i_unit_err,
      input  o_unit_rdy,
      input  o_dat, o_val, o_ctl, o_err,
      output i_rdy
   );
endinterface

// File: rtl/ec_fpk_elem_serialiser.sv
// Splits an Fp^k operand pair into NUM_ELEM element requests for one shared Fp unit and reassembles the results.
// Latency: 1 cycle input->first request; o_val 1 cycle after the last element result handshake.
// Backpressure: request slot stalls on i_unit_rdy; only the last result is held off while o_val waits on i_rdy.
// Ports: i_clk, i_rst_n (async active-low) plus bus (ec_fpk_elem_serialiser_if.slave), see the interface file.
// Optional build macro EC_FPK_SERIAL_IDX_CHECK_EN: returned index tags are checked against the collect
// position and any mismatch forces o_err for that transaction.
module ec_fpk_elem_serialiser #(
   parameter int FE_BITS  = 381,
   parameter int NUM_ELEM = 2,
   parameter int CTL_BITS = 16,
   parameter int IDX_BIT  = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   ec_fpk_elem_serialiser_if.slave   bus
);
   localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

   generate
      if (NUM_ELEM < 1 || NUM_ELEM > 16) begin : g_bad_num_elem
         $fatal(1, "ec_fpk_elem_serialiser: NUM_ELEM must be in 1..16");
      end
      if (IDX_BIT + IDX_W > CTL_BITS) begin : g_bad_idx_field
         $fatal(1, "ec_fpk_elem_serialiser: index field does not fit in ctl");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Issue side
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]      issue_idx;
   logic                  slot_free;
   logic                  issue_last;
   logic [FE_BITS-1:0]    a_sel;
   logic [FE_BITS-1:0]    b_sel;
   logic [CTL_BITS-1:0]   issue_ctl;

   logic [2*FE_BITS-1:0]  unit_dat_q;
   logic                  unit_val_q;
   logic [CTL_BITS-1:0]   unit_ctl_q;
   logic                  unit_sop_q;
   logic                  unit_eop_q;
   logic                  unit_err_q;

   assign slot_free  = ~unit_val_q | bus.i_unit_rdy;
   assign issue_last = (issue_idx == LAST_IDX);
   // The upstream word is released only once its final element has been loaded.
   assign bus.o_rdy  = slot_free & issue_last;

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int j = 0; j < NUM_ELEM; j++) begin
         if (issue_idx == IDX_W'(j)) begin
            a_sel = bus.i_dat[j*FE_BITS +: FE_BITS];
            b_sel = bus.i_dat[(NUM_ELEM+j)*FE_BITS +: FE_BITS];
         end
      end
      issue_ctl = bus.i_ctl;
      issue_ctl[IDX_BIT +: IDX_W] = issue_idx;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         issue_idx  <= '0;
         unit_dat_q <= '0;
         unit_val_q <= 1'b0;
         unit_ctl_q <= '0;
         unit_sop_q <= 1'b0;
         unit_eop_q <= 1'b0;
         unit_err_q <= 1'b0;
      end else if (slot_free) begin
         // Slot is empty or being drained this edge: refill or go idle.
         unit_val_q <= bus.i_val;
         if (bus.i_val) begin
            unit_dat_q <= {b_sel, a_sel};
            unit_ctl_q <= issue_ctl;
            unit_sop_q <= (issue_idx == '0);
            unit_eop_q <= issue_last;
            unit_err_q <= bus.i_err;
            issue_idx  <= issue_last ? '0 : issue_idx + 1'b1;
         end
      end
   end

   assign bus.o_unit_dat = unit_dat_q;
   assign bus.o_unit_val = unit_val_q;
   assign bus.o_unit_ctl = unit_ctl_q;
   assign bus.o_unit_sop = unit_sop_q;
   assign bus.o_unit_eop = unit_eop_q;
   assign bus.o_unit_err = unit_err_q;

   // ------------------------------------------------------------------
   // Collect side
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]             collect_idx;
   logic                         collect_last;
   logic                         unit_rdy;
   logic                         res_hs;
   logic                         idx_bad;
   logic                         acc_q;
   logic                         acc_next;
   logic [NUM_ELEM*FE_BITS-1:0]  shadow_q;
   logic [NUM_ELEM*FE_BITS-1:0]  merged;
   logic [CTL_BITS-1:0]          res_ctl;

   logic [NUM_ELEM*FE_BITS-1:0]  out_dat_q;
   logic                         out_val_q;
   logic [CTL_BITS-1:0]          out_ctl_q;
   logic                         out_err_q;

   assign collect_last = (collect_idx == LAST_IDX);
   // Non-final elements land in the shadow copy, so only the final one must wait for the output register.
   assign unit_rdy     = ~collect_last | ~out_val_q | bus.i_rdy;
   assign res_hs       = bus.i_unit_val & unit_rdy;

`ifdef EC_FPK_SERIAL_IDX_CHECK_EN
   assign idx_bad = (bus.i_unit_ctl[IDX_BIT +: IDX_W] != collect_idx);
`else
   assign idx_bad = 1'b0;
`endif

   // Error accumulation restarts with the first element of each transaction.
   assign acc_next = ((collect_idx == '0) ? 1'b0 : acc_q) | bus.i_unit_err | idx_bad;

   always_comb begin
      merged = shadow_q;
      for (int j = 0; j < NUM_ELEM; j++) begin
         if (collect_idx == IDX_W'(j)) begin
            merged[j*FE_BITS +: FE_BITS] = bus.i_unit_dat;
         end
      end
      res_ctl = bus.i_unit_ctl;
      res_ctl[IDX_BIT +: IDX_W] = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         collect_idx <= '0;
         acc_q       <= 1'b0;
         shadow_q    <= '0;
         out_dat_q   <= '0;
         out_val_q   <= 1'b0;
         out_ctl_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         if (res_hs) begin
            shadow_q    <= merged;
            acc_q       <= acc_next;
            collect_idx <= collect_last ? '0 : collect_idx + 1'b1;
         end
         // A new completion replaces a word being drained in the same cycle.
         if (res_hs && collect_last) begin
            out_val_q <= 1'b1;
            out_dat_q <= merged;
            out_ctl_q <= res_ctl;
            out_err_q <= acc_next;
         end else if (bus.i_rdy) begin
            out_val_q <= 1'b0;
         end
      end
   end

   assign bus.o_unit_rdy = unit_rdy;
   assign bus.o_dat      = out_dat_q;
   assign bus.o_val      = out_val_q;
   assign bus.o_ctl      = out_ctl_q;
   assign bus.o_err      = out_err_q;
endmodule

// File: tb/tb_ec_fpk_elem_serialiser.sv
// Self-checking bench for ec_fpk_elem_serialiser with NUM_ELEM=3, FE_BITS=8 and a 1-cycle mod-251 adder unit.
// Latency: n/a.
// Backpressure: random i_unit_rdy / i_rdy / i_val gaps per phase.
module tb_ec_fpk_elem_serialiser;
   localparam int FE = 8;
   localparam int NE = 3;
   localparam int CB = 16;
   localparam int IB = 8;
`ifdef EC_FPK_SERIAL_IDX_CHECK_EN
   localparam bit IDXCHK = 1'b1;
`else
   localparam bit IDXCHK = 1'b0;
`endif

   typedef struct packed {
      logic [NE-1:0][7:0] a;
      logic [NE-1:0][7:0] b;
      logic [15:0]        ctl;   // bit0: unit flags error on elem 1, bit1: unit corrupts idx 1 -> 2
      logic               err;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ec_fpk_elem_serialiser_if #(.FE_BITS(FE), .NUM_ELEM(NE), .CTL_BITS(CB)) bus ();

   ec_fpk_elem_serialiser #(.FE_BITS(FE), .NUM_ELEM(NE), .CTL_BITS(CB), .IDX_BIT(IB)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   txn_t        txn_q[$];
   logic [34:0] exp_iss_q[$];   // {B, A, ctl, sop, eop, err}
   logic [40:0] exp_out_q[$];   // {err, ctl, dat}
   logic [24:0] unit_q[$];      // {err, ctl, dat}

   bit cur_act = 0;
   bit res_taken = 0;
   int unit_rdy_pct = 100, rdy_pct = 100, val_pct = 100;
   int rdy_pulses, out_cnt, iss_cnt, cur_run, max_run;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] addm(input logic [7:0] a, input logic [7:0] b);
      int s;
      s = (int'(a) + int'(b)) % 251;
      return 8'(s);
   endfunction

   task automatic push_txn(input logic [23:0] a, input logic [23:0] b, input logic [15:0] ctl, input logic err);
      txn_t t;
      t.a = a;
      t.b = b;
      t.ctl = ctl;
      t.err = err;
      txn_q.push_back(t);
   endtask

   // Present the next transaction upstream and record what it must produce.
   task automatic launch();
      txn_t        t;
      logic [15:0] c;
      logic [23:0] d;
      logic        e;
      t = txn_q.pop_front();
      d = '0;
      for (int j = 0; j < NE; j++) begin
         c = t.ctl;
         c[IB +: 2] = 2'(j);
         exp_iss_q.push_back({t.b[j], t.a[j], c, (j == 0), (j == NE-1), t.err});
         d[j*8 +: 8] = addm(t.a[j], t.b[j]);
      end
      e = t.err | t.ctl[0] | (IDXCHK & t.ctl[1]);
      c = t.ctl;
      c[IB +: 2] = 2'b00;
      exp_out_q.push_back({e, c, d});
      bus.i_dat = {t.b, t.a};
      bus.i_ctl = t.ctl;
      bus.i_err = t.err;
      cur_act = 1;
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic cycle();
      logic [24:0] r;
      logic [34:0] ei;
      logic [40:0] eo;
      logic [15:0] rc;
      logic        re;
      // drive
      if (res_taken || !bus.i_unit_val) begin
         if (unit_q.size() > 0) begin
            r = unit_q.pop_front();
            bus.i_unit_val = 1'b1;
            bus.i_unit_dat = r[7:0];
            bus.i_unit_ctl = r[23:8];
            bus.i_unit_err = r[24];
         end else begin
            bus.i_unit_val = 1'b0;
         end
      end
      bus.i_unit_rdy = ($urandom_range(0, 99) < unit_rdy_pct);
      bus.i_rdy      = ($urandom_range(0, 99) < rdy_pct);
      if (!cur_act && txn_q.size() > 0 && $urandom_range(0, 99) < val_pct) launch();
      bus.i_val = cur_act;
      #2;
      // observe the handshakes of the coming edge
      if (bus.o_unit_val && bus.i_unit_rdy) begin
         iss_cnt++;
         if (exp_iss_q.size() == 0) check("iss_unexpected", 1, 0);
         else begin
            ei = exp_iss_q.pop_front();
            check("iss_elem", {bus.o_unit_dat, bus.o_unit_ctl, bus.o_unit_sop, bus.o_unit_eop, bus.o_unit_err}, ei);
         end
         rc = bus.o_unit_ctl;
         re = bus.o_unit_err;
         if (rc[0] && rc[IB +: 2] == 2'd1) re = 1'b1;
         if (rc[1] && rc[IB +: 2] == 2'd1) rc[IB +: 2] = 2'd2;
         unit_q.push_back({re, rc, addm(bus.o_unit_dat[7:0], bus.o_unit_dat[15:8])});
      end
      res_taken = bus.i_unit_val && bus.o_unit_rdy;
      if (bus.o_val && bus.i_rdy) begin
         out_cnt++;
         if (exp_out_q.size() == 0) check("out_unexpected", 1, 0);
         else begin
            eo = exp_out_q.pop_front();
            check("o_dat", bus.o_dat, eo[23:0]);
            check("o_ctl", bus.o_ctl, eo[39:24]);
            check("o_err", bus.o_err, eo[40]);
         end
      end
      if (bus.o_rdy) rdy_pulses++;
      if (bus.i_val && bus.o_rdy) cur_act = 0;
      if (bus.o_unit_val) begin
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
      end else cur_run = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_phase(input string tag, input int budget);
      int n;
      n = 0;
      rdy_pulses = 0; out_cnt = 0; iss_cnt = 0; cur_run = 0; max_run = 0;
      while ((txn_q.size() > 0 || cur_act || exp_out_q.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_pending"}, exp_out_q.size(), 0);
   endtask

   task automatic set_rates(input int u, input int r, input int v);
      unit_rdy_pct = u;
      rdy_pct = r;
      val_pct = v;
   endtask

   initial begin
      bus.i_dat = '0; bus.i_val = 0; bus.i_ctl = '0; bus.i_err = 0;
      bus.i_unit_rdy = 0; bus.i_unit_dat = '0; bus.i_unit_val = 0;
      bus.i_unit_ctl = '0; bus.i_unit_err = 0; bus.i_rdy = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_o_unit_val", bus.o_unit_val, 0);
      check("rst_o_val", bus.o_val, 0);
      check("rst_o_err", bus.o_err, 0);
      check("rst_o_dat", bus.o_dat, 0);
      check("rst_o_ctl", bus.o_ctl, 0);
      check("rst_o_unit_dat", bus.o_unit_dat, 0);
      check("rst_o_unit_ctl", bus.o_unit_ctl, 0);
      check("rst_o_rdy", bus.o_rdy, 0);
      check("rst_o_unit_rdy", bus.o_unit_rdy, 1);
      rst_n = 1;
      @(posedge clk);
      #1;

      // basic: {10,20,250} + {5,6,3} -> {15,26,2}
      set_rates(100, 100, 100);
      push_txn({8'd250, 8'd20, 8'd10}, {8'd3, 8'd6, 8'd5}, 16'h5A00, 1'b0);
      run_phase("basic", 100);
      repeat (3) cycle();
      check("basic_rdy_pulses", rdy_pulses, 1);
      check("basic_out_cnt", out_cnt, 1);

      // back-to-back: 4 transactions at full rate
      for (int i = 0; i < 4; i++)
         push_txn(24'($urandom) & 24'h7F7F7F, 24'($urandom) & 24'h7F7F7F, 16'($urandom) & 16'hFFFC, 1'b0);
      run_phase("b2b", 200);
      repeat (3) cycle();
      check("b2b_val_run", max_run, 12);
      check("b2b_out_cnt", out_cnt, 4);

      // unit error on element 1 only, then a clean transaction
      push_txn({8'd7, 8'd8, 8'd9}, {8'd1, 8'd2, 8'd3}, 16'h0001, 1'b0);
      push_txn({8'd7, 8'd8, 8'd9}, {8'd1, 8'd2, 8'd3}, 16'h0000, 1'b0);
      run_phase("err", 200);

      // unit corrupts the returned index of element 1
      push_txn({8'd40, 8'd30, 8'd20}, {8'd4, 8'd3, 8'd2}, 16'h0002, 1'b0);
      run_phase("idx", 200);

      // random backpressure and gaps
      set_rates(50, 30, 60);
      for (int i = 0; i < 200; i++)
         push_txn({8'($urandom_range(0, 250)), 8'($urandom_range(0, 250)), 8'($urandom_range(0, 250))},
                  {8'($urandom_range(0, 250)), 8'($urandom_range(0, 250)), 8'($urandom_range(0, 250))},
                  16'($urandom) & 16'hFFFC, ($urandom_range(0, 9) == 0));
      run_phase("rand", 20000);
      check("rand_out_cnt", out_cnt, 200);
      repeat (5) cycle();

      // reset after two of three elements are issued
      set_rates(100, 100, 100);
      push_txn({8'd50, 8'd60, 8'd70}, {8'd1, 8'd1, 8'd1}, 16'h0000, 1'b0);
      iss_cnt = 0;
      for (int n = 0; n < 50 && iss_cnt < 2; n++) cycle();
      check("rst_mid_issued", iss_cnt, 2);
      rst_n = 0;
      #1;
      check("rst_mid_o_unit_val", bus.o_unit_val, 0);
      check("rst_mid_o_val", bus.o_val, 0);
      check("rst_mid_o_rdy", bus.o_rdy, 0);
      txn_q.delete(); exp_iss_q.delete(); exp_out_q.delete(); unit_q.delete();
      cur_act = 0; res_taken = 0;
      bus.i_val = 0; bus.i_unit_val = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk);
      #1;
      push_txn({8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1}, 16'h0300, 1'b0);
      run_phase("post_rst", 100);
      repeat (3) cycle();
      check("post_rst_out_cnt", out_cnt, 1);
      check("iss_leftover", exp_iss_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ec_fpk_elem_serialiser.md
Name: ec_fpk_elem_serialiser

Overview:
- Element-wise serialiser/deserialiser between an Fp^k-wide operand stream and a single shared Fp (FE-wide) arithmetic unit (add, sub, or any 2-operand element op).
- Generalises the fixed 2-element Fp^2 add/sub split to NUM_ELEM elements.
- Adds a per-element index tag in ctl, sop/eop framing, error OR-reduction, and full-rate pipelined issue and collect.
- Sits between an Fp^k point-arithmetic core and a resource_share arbiter in front of the FE adder or subtractor.

Parameters:
- FE_BITS, 381, width of one Fp element.
- NUM_ELEM, 2, elements per Fp^k value; range 1..16.
- CTL_BITS, 16, ctl width carried through.
- IDX_BIT, 8, LSB of the element-index field inside ctl.
- IDX_W = max(1, $clog2(NUM_ELEM)), derived localparam; not overridable.
- Constraint: IDX_BIT+IDX_W <= CTL_BITS. Violation gives an elaboration error via $fatal.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_dat  in  2*NUM_ELEM*FE_BITS  operand A element j at [j*FE_BITS +: FE_BITS]; operand B element j at [(NUM_ELEM+j)*FE_BITS +: FE_BITS]
- i_val  in  1  input valid
- i_ctl  in  CTL_BITS  transaction ctl
- i_err  in  1  input error flag
- o_rdy  out  1  input consumed (pulses on last element issue)
- o_unit_dat  out  2*FE_BITS  {B_j, A_j}; A_j in the low half
- o_unit_val  out  1  element request valid
- o_unit_ctl  out  CTL_BITS  i_ctl with [IDX_BIT +: IDX_W] = j
- o_unit_sop  out  1  high when j==0
- o_unit_eop  out  1  high when j==NUM_ELEM-1
- o_unit_err  out  1  copy of i_err
- i_unit_rdy  in  1  unit accepts request
- i_unit_dat  in  FE_BITS  element result
- i_unit_val  in  1  result valid
- i_unit_ctl  in  CTL_BITS  result ctl (index tag returned)
- i_unit_err  in  1  result error
- o_unit_rdy  out  1  block accepts result
- o_dat  out  NUM_ELEM*FE_BITS  reassembled result; element j at [j*FE_BITS +: FE_BITS]
- o_val  out  1  output valid
- o_ctl  out  CTL_BITS  ctl of the last element result, index field forced to 0
- o_err  out  1  OR of i_unit_err over all elements of the transaction
- i_rdy  in  1  downstream ready

Behaviour:
Reset (async assert, sync deassert):
- o_unit_val, o_val, o_err, o_rdy-related state at 0.
- issue_idx and collect_idx at 0.
- o_dat, o_ctl, o_unit_dat and o_unit_ctl at 0.

Issue side:
- Registered source.
- Slot free = ~o_unit_val | i_unit_rdy.
- When slot free and i_val: load element issue_idx into o_unit_* and set o_unit_val=1.
- issue_idx increments on each load and wraps to 0 after NUM_ELEM-1.
- When slot not free: all o_unit_* hold stable.
- o_rdy (combinational) = slot free & (issue_idx==NUM_ELEM-1). The upstream holds i_dat/i_ctl stable until o_rdy.
- Throughput: 1 element per cycle; one transaction per NUM_ELEM cycles with no backpressure.
- NUM_ELEM=1: o_rdy = slot free; sop and eop both 1.

Collect side:
- o_unit_rdy = (collect_idx != NUM_ELEM-1) | ~o_val | i_rdy.
- On a result handshake: write i_unit_dat into o_dat element collect_idx and increment collect_idx (wrap as on the issue side).
- Error accumulator is cleared on collect_idx==0 and ORs in i_unit_err.
- Last element handshake:
  - o_val <= 1 on the next edge.
  - o_ctl <= i_unit_ctl with the index field zeroed.
  - o_err <= acc | i_unit_err.
- Results are placed in arrival order; the external unit returns results in order.
- Latency: o_val rises 1 cycle after the last element result handshake. Input to first unit request is 1 cycle.
- o_val clears on o_val & i_rdy unless a new last element is accepted in the same cycle, in which case it stays 1 with new data.
- Elements 0..NUM_ELEM-2 of the next transaction may be written while o_val is held. o_dat is double-buffered: a shadow register is copied to the output on the last element.

Simultaneous events:
- Issue and collect run concurrently and independently.
- Reset mid-transaction discards all partial state; no output is produced for the aborted transaction.

Optional Feature:
- Macro: EC_FPK_SERIAL_IDX_CHECK_EN.
- Defined: each result's ctl[IDX_BIT +: IDX_W] is compared to collect_idx. On mismatch, the transaction's o_err is forced to 1; placement still uses collect_idx.
- Not defined: no comparison; the index field is ignored on the collect side.

Test Plan:
- NUM_ELEM=3, FE_BITS=8, unit = 1-cycle adder mod 251, i_rdy=1. Input A={10,20,250}, B={5,6,3}:
  - o_unit_ctl idx sequence 0,1,2 with sop on 0 and eop on 2.
  - o_dat={15,26,2}, o_err=0, o_rdy pulses once.
- Back-to-back transactions with i_val held high for 4 transactions: o_unit_val high continuously for 12 cycles; 4 outputs, each correct.
- Random i_unit_rdy (50%) and i_rdy (30%) over 200 transactions: no lost or duplicated elements; outputs match the scoreboard in order.
- i_unit_err=1 on element 1 only: that transaction has o_err=1; the following transaction has o_err=0.
- Assert i_rst_n low after 2 of 3 elements are issued: all valids drop immediately. After release, a fresh transaction A={1,1,1}, B={1,1,1} gives o_dat={2,2,2}.
- With EC_FPK_SERIAL_IDX_CHECK_EN, the unit corrupts idx 1 to 2: o_err=1 and data is still placed in order. Without the macro, o_err=0.
